// File: rtl/tlul_host_arb2.sv
// rtl/tlul_host_arb2.sv - two-host to one-device TL-UL arbiter with round-robin grant,
// A-beat grant lock, host ID tagging in a_source[7] and per-host outstanding throttling.
module tlul_host_arb2 #(
  parameter int MaxOutstanding = 2,
  parameter bit Host0First     = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       h_a_valid_i,
  output logic [1:0]       h_a_ready_o,
  input  logic [1:0][2:0]  h_a_opcode_i,
  input  logic [1:0][6:0]  h_a_source_i,
  input  logic [1:0][31:0] h_a_address_i,
  input  logic [1:0][3:0]  h_a_mask_i,
  input  logic [1:0][31:0] h_a_data_i,
  output logic [1:0]       h_d_valid_o,
  input  logic [1:0]       h_d_ready_i,
  output logic [2:0]       h_d_opcode_o,
  output logic [6:0]       h_d_source_o,
  output logic [31:0]      h_d_data_o,
  output logic             h_d_error_o,
  output logic             d_a_valid_o,
  input  logic             d_a_ready_i,
  output logic [2:0]       d_a_opcode_o,
  output logic [7:0]       d_a_source_o,
  output logic [31:0]      d_a_address_o,
  output logic [3:0]       d_a_mask_o,
  output logic [31:0]      d_a_data_o,
  input  logic             d_d_valid_i,
  output logic             d_d_ready_o,
  input  logic [2:0]       d_d_opcode_i,
  input  logic [7:0]       d_d_source_i,
  input  logic [31:0]      d_d_data_i,
  input  logic             d_d_error_i,
  output logic             busy_o,
  output logic             err_unexpected_o
);

  localparam logic [3:0] MaxCnt = 4'(MaxOutstanding);

  logic       lock_q, lock_d;
  logic       locked_gnt_q, locked_gnt_d;
  logic       ptr_q, ptr_d;
  logic [3:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic       err_q, err_d;

  logic [1:0] elig;
  logic       gnt, a_valid, a_hs, d_rt, d_hs;
  logic       inc0, inc1, dec0, dec1;

  assign elig = {h_a_valid_i[1] && (cnt1_q < MaxCnt), h_a_valid_i[0] && (cnt0_q < MaxCnt)};

  // A locked beat must stay presented unchanged until it handshakes.
  always_comb begin
    gnt     = ptr_q;
    a_valid = 1'b0;
    if (lock_q) begin
      gnt     = locked_gnt_q;
      a_valid = h_a_valid_i[locked_gnt_q];
    end else begin
      unique case (elig)
        2'b11:   gnt = ptr_q;
        2'b01:   gnt = 1'b0;
        2'b10:   gnt = 1'b1;
        default: gnt = ptr_q;
      endcase
      a_valid = |elig;
    end
  end

  assign d_a_valid_o   = a_valid;
  assign d_a_opcode_o  = h_a_opcode_i[gnt];
  assign d_a_source_o  = {gnt, h_a_source_i[gnt]};
  assign d_a_address_o = h_a_address_i[gnt];
  assign d_a_mask_o    = h_a_mask_i[gnt];
  assign d_a_data_o    = h_a_data_i[gnt];
  assign a_hs          = a_valid && d_a_ready_i;

  always_comb begin
    h_a_ready_o      = 2'b00;
    h_a_ready_o[gnt] = a_valid && d_a_ready_i;
  end

  assign d_rt         = d_d_source_i[7];
  assign d_d_ready_o  = h_d_ready_i[d_rt];
  assign d_hs         = d_d_valid_i && d_d_ready_o;
  assign h_d_opcode_o = d_d_opcode_i;
  assign h_d_source_o = d_d_source_i[6:0];
  assign h_d_data_o   = d_d_data_i;
  assign h_d_error_o  = d_d_error_i;

  always_comb begin
    h_d_valid_o       = 2'b00;
    h_d_valid_o[d_rt] = d_d_valid_i;
  end

  assign inc0 = a_hs && !gnt;
  assign inc1 = a_hs && gnt;
  assign dec0 = d_hs && !d_rt;
  assign dec1 = d_hs && d_rt;

  function automatic logic [3:0] cnt_next(input logic [3:0] c, input logic inc, input logic dec);
    if (inc && !dec)              return c + 4'd1;
    if (dec && !inc && c != 4'd0) return c - 4'd1;
    return c;
  endfunction

  always_comb begin
    lock_d       = lock_q;
    locked_gnt_d = locked_gnt_q;
    ptr_d        = ptr_q;
    if (a_hs) begin
      lock_d = 1'b0;
      ptr_d  = ~gnt;
    end else if (a_valid) begin
      lock_d       = 1'b1;
      locked_gnt_d = gnt;
    end
    cnt0_d = cnt_next(cnt0_q, inc0, dec0);
    cnt1_d = cnt_next(cnt1_q, inc1, dec1);
    // A response for a host with nothing in flight (e.g. issued before a reset).
    err_d  = err_q || (dec0 && !inc0 && cnt0_q == 4'd0) || (dec1 && !inc1 && cnt1_q == 4'd0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q       <= 1'b0;
      locked_gnt_q <= 1'b0;
      ptr_q        <= Host0First ? 1'b0 : 1'b1;
      cnt0_q       <= 4'd0;
      cnt1_q       <= 4'd0;
      err_q        <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      locked_gnt_q <= locked_gnt_d;
      ptr_q        <= ptr_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
      err_q        <= err_d;
    end
  end

  assign busy_o           = lock_q || (cnt0_q != 4'd0) || (cnt1_q != 4'd0);
  assign err_unexpected_o = err_q;

endmodule

// File: tb/tb_tlul_host_arb2.sv
// tb/tb_tlul_host_arb2.sv - scoreboard bench for tlul_host_arb2: directed A/D traffic,
// expected beats queued by stimulus and compared by negedge monitors.
module tb_tlul_host_arb2;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [1:0]       h_a_valid_i;
  logic [1:0]       h_a_ready_o;
  logic [1:0][2:0]  h_a_opcode_i;
  logic [1:0][6:0]  h_a_source_i;
  logic [1:0][31:0] h_a_address_i;
  logic [1:0][3:0]  h_a_mask_i;
  logic [1:0][31:0] h_a_data_i;
  logic [1:0]       h_d_valid_o;
  logic [1:0]       h_d_ready_i;
  logic [2:0]       h_d_opcode_o;
  logic [6:0]       h_d_source_o;
  logic [31:0]      h_d_data_o;
  logic             h_d_error_o;
  logic             d_a_valid_o;
  logic             d_a_ready_i;
  logic [2:0]       d_a_opcode_o;
  logic [7:0]       d_a_source_o;
  logic [31:0]      d_a_address_o;
  logic [3:0]       d_a_mask_o;
  logic [31:0]      d_a_data_o;
  logic             d_d_valid_i;
  logic             d_d_ready_o;
  logic [2:0]       d_d_opcode_i;
  logic [7:0]       d_d_source_i;
  logic [31:0]      d_d_data_i;
  logic             d_d_error_i;
  logic             busy_o;
  logic             err_unexpected_o;

  tlul_host_arb2 #(.MaxOutstanding(2), .Host0First(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .h_a_valid_i(h_a_valid_i), .h_a_ready_o(h_a_ready_o), .h_a_opcode_i(h_a_opcode_i),
    .h_a_source_i(h_a_source_i), .h_a_address_i(h_a_address_i), .h_a_mask_i(h_a_mask_i),
    .h_a_data_i(h_a_data_i), .h_d_valid_o(h_d_valid_o), .h_d_ready_i(h_d_ready_i),
    .h_d_opcode_o(h_d_opcode_o), .h_d_source_o(h_d_source_o), .h_d_data_o(h_d_data_o),
    .h_d_error_o(h_d_error_o), .d_a_valid_o(d_a_valid_o), .d_a_ready_i(d_a_ready_i),
    .d_a_opcode_o(d_a_opcode_o), .d_a_source_o(d_a_source_o), .d_a_address_o(d_a_address_o),
    .d_a_mask_o(d_a_mask_o), .d_a_data_o(d_a_data_o), .d_d_valid_i(d_d_valid_i),
    .d_d_ready_o(d_d_ready_o), .d_d_opcode_i(d_d_opcode_i), .d_d_source_i(d_d_source_i),
    .d_d_data_i(d_d_data_i), .d_d_error_i(d_d_error_i), .busy_o(busy_o),
    .err_unexpected_o(err_unexpected_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  logic [78:0] exp_a[$];
  logic [44:0] exp_d[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_a(input int n, input logic [6:0] src, input logic [31:0] addr);
    h_a_source_i[n]  = src;
    h_a_address_i[n] = addr;
    h_a_opcode_i[n]  = 3'd4;
    h_a_mask_i[n]    = 4'hF;
    h_a_data_i[n]    = addr ^ 32'hA5A5_0000;
  endtask

  task automatic push_a(input int n, input logic [6:0] src, input logic [31:0] addr);
    logic id;
    id = n[0];
    exp_a.push_back({id, src, 3'd4, addr, 4'hF, addr ^ 32'hA5A5_0000});
  endtask

  task automatic send_d(input logic [7:0] src, input logic [31:0] data, input logic e);
    logic [1:0] rt;
    rt = src[7] ? 2'b10 : 2'b01;
    d_d_valid_i  = 1'b1;
    d_d_source_i = src;
    d_d_opcode_i = 3'd1;
    d_d_data_i   = data;
    d_d_error_i  = e;
    exp_d.push_back({rt, 3'd1, src[6:0], data, e});
  endtask

  // Monitors: every handshake must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (d_a_valid_o && d_a_ready_i) begin
        if (exp_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_beat: got unexpected beat src %0h required none", d_a_source_o);
        end else begin
          chk("a_beat", {d_a_source_o, d_a_opcode_o, d_a_address_o, d_a_mask_o, d_a_data_o},
              exp_a.pop_front());
        end
      end
      if (d_d_valid_i && d_d_ready_o) begin
        if (exp_d.size() == 0) begin
          checks++; errors++;
          $display("FAIL d_beat: got unexpected beat src %0h required none", d_d_source_i);
        end else begin
          chk("d_beat", {h_d_valid_o, h_d_opcode_o, h_d_source_o, h_d_data_o, h_d_error_o},
              exp_d.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    logic pg;
    rst_i = 1'b1;
    h_a_valid_i = '0; h_a_opcode_i = '0; h_a_source_i = '0; h_a_address_i = '0;
    h_a_mask_i = '0; h_a_data_i = '0; h_d_ready_i = 2'b11; d_a_ready_i = 1'b0;
    d_d_valid_i = 1'b0; d_d_opcode_i = '0; d_d_source_i = '0; d_d_data_i = '0; d_d_error_i = 1'b0;
    pg = 1'b0;

    @(negedge clk_i);
    chk("rst_a_valid", d_a_valid_o, 0);
    chk("rst_a_ready", h_a_ready_o, 0);
    chk("rst_d_valid", h_d_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_unexpected_o, 0);
    tick();
    rst_i = 1'b0;
    tick();

    // Single host, no stall
    set_a(0, 7'h05, 32'h1000); h_a_valid_i = 2'b01; d_a_ready_i = 1'b1;
    push_a(0, 7'h05, 32'h1000);
    @(negedge clk_i);
    chk("t1_ready", h_a_ready_o, 2'b01);
    chk("t1_src", d_a_source_o, 8'h05);
    tick(); h_a_valid_i = 2'b00;
    @(negedge clk_i); chk("t1_busy", busy_o, 1);
    tick(); send_d(8'h05, 32'hCAFE_0001, 1'b0);
    @(negedge clk_i); chk("t1_dvalid", h_d_valid_o, 2'b01);
    tick(); d_d_valid_i = 1'b0;
    @(negedge clk_i); chk("t1_idle", busy_o, 0);
    tick();

    // Round-robin: pointer now favours host 1
    set_a(0, 7'h11, 32'h2000); set_a(1, 7'h22, 32'h3000); h_a_valid_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = (i % 2 == 0);
      push_a(g ? 1 : 0, g ? 7'h22 : 7'h11, g ? 32'h3000 : 32'h2000);
      if (i > 0) send_d({pg, pg ? 7'h22 : 7'h11}, 32'hD000_0000 + i, 1'b0);
      @(negedge clk_i); chk("rr_msb", d_a_source_o[7], g);
      tick();
      pg = g;
    end
    h_a_valid_i = 2'b00; send_d(8'h11, 32'hD000_0004, 1'b0);
    tick(); d_d_valid_i = 1'b0;
    @(negedge clk_i); chk("rr_idle", busy_o, 0);
    tick();

    // Host1 alone so the pointer favours host 0, then the lock test
    set_a(1, 7'h33, 32'h4000); h_a_valid_i = 2'b10; push_a(1, 7'h33, 32'h4000);
    tick(); h_a_valid_i = 2'b00; send_d(8'hB3, 32'h0000_4444, 1'b0);
    tick(); d_d_valid_i = 1'b0;
    set_a(1, 7'h34, 32'h4100); set_a(0, 7'h12, 32'h2100);
    h_a_valid_i = 2'b10; d_a_ready_i = 1'b0;
    @(negedge clk_i); chk("lk_src0", d_a_source_o, 8'hB4);
    tick(); h_a_valid_i = 2'b11;
    repeat (2) begin
      @(negedge clk_i);
      chk("lk_src", d_a_source_o, 8'hB4);
      chk("lk_addr", d_a_address_o, 32'h4100);
      chk("lk_rdy", h_a_ready_o, 2'b00);
      tick();
    end
    d_a_ready_i = 1'b1; push_a(1, 7'h34, 32'h4100);
    @(negedge clk_i); chk("lk_rel", h_a_ready_o, 2'b10);
    tick(); h_a_valid_i = 2'b01; push_a(0, 7'h12, 32'h2100);
    @(negedge clk_i); chk("lk_next", d_a_source_o, 8'h12);
    tick(); h_a_valid_i = 2'b00; send_d(8'hB4, 32'h0000_5555, 1'b1);
    tick(); send_d(8'h12, 32'h0000_6666, 1'b0);
    tick(); d_d_valid_i = 1'b0;

    // Throttle at two outstanding, then simultaneous A and D on host 0
    set_a(0, 7'h06, 32'h5000); h_a_valid_i = 2'b01; push_a(0, 7'h06, 32'h5000);
    tick(); set_a(0, 7'h06, 32'h5004); push_a(0, 7'h06, 32'h5004);
    tick();
    @(negedge clk_i);
    chk("th_block_v", d_a_valid_o, 0);
    chk("th_block_r", h_a_ready_o, 2'b00);
    tick(); set_a(1, 7'h44, 32'h6000); h_a_valid_i = 2'b11; push_a(1, 7'h44, 32'h6000);
    @(negedge clk_i); chk("th_h1", h_a_ready_o, 2'b10);
    tick(); h_a_valid_i = 2'b01; send_d(8'h06, 32'h0000_7001, 1'b0);
    @(negedge clk_i); chk("th_still", h_a_ready_o, 2'b00);
    tick(); d_d_valid_i = 1'b0; set_a(0, 7'h06, 32'h5008); push_a(0, 7'h06, 32'h5008);
    @(negedge clk_i); chk("th_again", h_a_ready_o, 2'b01);
    tick(); h_a_valid_i = 2'b00; send_d(8'h06, 32'h0000_7002, 1'b0);
    tick(); set_a(0, 7'h06, 32'h500C); h_a_valid_i = 2'b01; push_a(0, 7'h06, 32'h500C);
    send_d(8'h06, 32'h0000_7003, 1'b0);
    tick(); h_a_valid_i = 2'b00; send_d(8'h06, 32'h0000_7004, 1'b0);
    @(negedge clk_i); chk("sim_busy", busy_o, 1);
    tick(); send_d(8'hC4, 32'h0000_7005, 1'b0);
    tick(); d_d_valid_i = 1'b0;
    @(negedge clk_i);
    chk("sim_idle", busy_o, 0);
    chk("sim_noerr", err_unexpected_o, 0);
    tick();

    // Unexpected response for host 1
    send_d(8'h80, 32'h0000_8888, 1'b1);
    @(negedge clk_i); chk("ux_err_pre", err_unexpected_o, 0);
    tick(); d_d_valid_i = 1'b0;
    @(negedge clk_i);
    chk("ux_err", err_unexpected_o, 1);
    chk("ux_busy", busy_o, 0);
    tick();
    @(negedge clk_i); chk("ux_sticky", err_unexpected_o, 1);

    // Reset while host 1 is locked
    tick(); set_a(1, 7'h55, 32'h7000); h_a_valid_i = 2'b10; d_a_ready_i = 1'b0;
    tick(); h_a_valid_i = 2'b11;
    @(negedge clk_i);
    chk("rl_busy", busy_o, 1);
    chk("rl_gnt", d_a_source_o[7], 1);
    #2 rst_i = 1'b1;
    #1;
    chk("rl_rst_busy", busy_o, 0);
    chk("rl_rst_err", err_unexpected_o, 0);
    chk("rl_rst_gnt", d_a_source_o[7], 0);
    chk("rl_rst_dval", h_d_valid_o, 2'b00);
    h_a_valid_i = 2'b00;
    #1;
    chk("rl_rst_aval", d_a_valid_o, 0);
    chk("rl_rst_ardy", h_a_ready_o, 2'b00);
    tick(); tick();
    rst_i = 1'b0;
    tick();

    chk("a_queue_empty", exp_a.size(), 0);
    chk("d_queue_empty", exp_d.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
